// File: rtl/matrix_result_streamer.sv
// Streams a packed MxM result matrix out one element per handshake, with row/col tags.
// Build option: define MMAC_STREAM_TRANSPOSE_EN to emit elements in column-major (transposed) order.
module matrix_result_streamer #(
   parameter  int M_SIZE     = 4,
   parameter  int VAR_WIDTH  = 8,
   localparam int N_ELEM     = M_SIZE * M_SIZE,
   localparam int DATA_WIDTH = N_ELEM * VAR_WIDTH,
   localparam int IDX_W      = (M_SIZE > 1) ? $clog2(M_SIZE) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  abort,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [VAR_WIDTH-1:0]  out_data,
   output logic [IDX_W-1:0]      out_row,
   output logic [IDX_W-1:0]      out_col,
   output logic                  out_last,
   output logic                  busy
);

   localparam int               CNT_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_ELEM - 1);
   localparam logic [CNT_W-1:0] M_L       = CNT_W'(M_SIZE);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;

   logic [CNT_W-1:0]       quo, rem, elem_idx;
   logic [IDX_W-1:0]       row, col;

   // Element e sits MSB-first: index 0 occupies the top VAR_WIDTH bits.
   function automatic logic [VAR_WIDTH-1:0] pick_elem(input logic [DATA_WIDTH-1:0] mat,
                                                      input logic [CNT_W-1:0]      idx);
      logic [VAR_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         if (idx == CNT_W'(i)) begin
            v = mat[DATA_WIDTH-1-i*VAR_WIDTH -: VAR_WIDTH];
         end
      end
      return v;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  shadow_d = load_data;
                  cnt_d    = '0;
                  state_d  = STREAM;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (cnt_q == LAST_BEAT) begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Beat counter splits into major/minor indices; their role as row/col depends on the order.
   always_comb begin
      quo = cnt_q / M_L;
      rem = cnt_q % M_L;
`ifdef MMAC_STREAM_TRANSPOSE_EN
      row = IDX_W'(rem);
      col = IDX_W'(quo);
`else
      row = IDX_W'(quo);
      col = IDX_W'(rem);
`endif
      elem_idx = CNT_W'(row) * M_L + CNT_W'(col);
   end

   assign load_ready = (state_q == IDLE);
   assign out_valid  = (state_q == STREAM);
   assign busy       = (state_q != IDLE);
   assign out_data   = pick_elem(shadow_q, elem_idx);
   assign out_row    = row;
   assign out_col    = col;
   assign out_last   = (state_q == STREAM) && (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer: vector table plus hand-written stream sequences.
// Honors MMAC_STREAM_TRANSPOSE_EN to switch expected element order.
module tb_matrix_result_streamer;

   localparam int M  = 4;
   localparam int VW = 8;
   localparam int NE = 16;
   localparam int DW = 128;

   logic          clock = 1'b0;
   logic          reset;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_data;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] out_data;
   logic [1:0]    out_row;
   logic [1:0]    out_col;
   logic          out_last;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   matrix_result_streamer #(.M_SIZE(M), .VAR_WIDTH(VW)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_last   (out_last),
      .busy       (busy)
   );

   typedef struct {
      logic       lv;
      int         dsel;
      logic       ordy;
      logic       ab;
      logic       e_lr;
      logic       e_ov;
      logic       e_busy;
      logic       e_last;
      logic [7:0] e_od;
      logic [1:0] e_row;
      logic [1:0] e_col;
   } vec_t;

   vec_t tbl[9];

`ifdef MMAC_STREAM_TRANSPOSE_EN
   localparam logic [7:0] B1D = 8'h04;
   localparam logic [1:0] B1R = 2'd1, B1C = 2'd0;
   localparam logic [7:0] B2D = 8'h08;
   localparam logic [1:0] B2R = 2'd2, B2C = 2'd0;
`else
   localparam logic [7:0] B1D = 8'h01;
   localparam logic [1:0] B1R = 2'd0, B1C = 2'd1;
   localparam logic [7:0] B2D = 8'h02;
   localparam logic [1:0] B2R = 2'd0, B2C = 2'd2;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] build_pat();
      logic [DW-1:0] p;
      p = '0;
      for (int e = 0; e < NE; e++) p[DW-1-e*VW -: VW] = 8'(e);
      return p;
   endfunction

   // Reference ordering of a beat index into (data,row,col) for the loaded 0x00..0x0F pattern.
   function automatic logic [31:0] exp_data(input int b);
`ifdef MMAC_STREAM_TRANSPOSE_EN
      return 32'((b % M) * M + b / M);
`else
      return 32'(b);
`endif
   endfunction

   function automatic logic [31:0] exp_row(input int b);
`ifdef MMAC_STREAM_TRANSPOSE_EN
      return 32'(b % M);
`else
      return 32'(b / M);
`endif
   endfunction

   function automatic logic [31:0] exp_col(input int b);
`ifdef MMAC_STREAM_TRANSPOSE_EN
      return 32'(b / M);
`else
      return 32'(b % M);
`endif
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
      check({tag, "_out_valid"},  32'(out_valid),  32'd0);
      check({tag, "_out_data"},   32'(out_data),   32'd0);
      check({tag, "_out_row"},    32'(out_row),    32'd0);
      check({tag, "_out_col"},    32'(out_col),    32'd0);
      check({tag, "_out_last"},   32'(out_last),   32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
   endtask

   task automatic idle_after(input string tag);
      #1;
      check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
      check({tag, "_out_valid"},  32'(out_valid),  32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
      @(negedge clock);
   endtask

   task automatic do_load(input logic [DW-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      #1;
      check("load_accept_ready", 32'(load_ready), 32'd1);
      @(negedge clock);
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   task automatic run_beats(input int n, input int stall_at, input int stall_len, input int ff_at);
      int beat, stalled, cyc;
      bit ff_done;
      beat = 0; stalled = 0; cyc = 0; ff_done = 1'b0;
      while (beat < n && cyc < 200) begin
         out_ready = !(beat == stall_at && stalled < stall_len);
         if (!out_ready) stalled++;
         if (beat == ff_at && !ff_done) begin
            load_valid = 1'b1;
            load_data  = '1;
            ff_done    = 1'b1;
         end
         #1;
         check("beat_out_valid", 32'(out_valid), 32'd1);
         check("beat_out_data",  32'(out_data),  exp_data(beat));
         check("beat_out_row",   32'(out_row),   exp_row(beat));
         check("beat_out_col",   32'(out_col),   exp_col(beat));
         check("beat_out_last",  32'(out_last),  32'(beat == NE - 1));
         if (load_valid) check("beat_load_ready", 32'(load_ready), 32'd0);
         if (out_ready) beat++;
         cyc++;
         @(negedge clock);
         load_valid = 1'b0;
         load_data  = '0;
      end
      if (beat < n) check("beat_timeout", 32'(beat), 32'(n));
      out_ready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] pat;
      pat        = build_pat();
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      abort      = 1'b0;
      out_ready  = 1'b0;

      #12;
      check_reset_vals("reset");
      @(negedge clock);
      reset = 1'b1;

      //           lv    dsel ordy  ab    lr    ov    busy  last  od     row   col
      tbl[0] = '{1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0};
      tbl[1] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0};
      tbl[2] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0};
      tbl[3] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B1D,   B1R,  B1C};
      tbl[4] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B1D,   B1R,  B1C};
      tbl[5] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, B2D,   B2R,  B2C};
      tbl[6] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, B2D,   B2R,  B2C};
      tbl[7] = '{1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0};
      tbl[8] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0};

      for (int i = 0; i < 9; i++) begin
         load_valid = tbl[i].lv;
         load_data  = (tbl[i].dsel == 1) ? pat : (tbl[i].dsel == 2) ? '1 : '0;
         out_ready  = tbl[i].ordy;
         abort      = tbl[i].ab;
         #1;
         check($sformatf("vec%0d_load_ready", i), 32'(load_ready), 32'(tbl[i].e_lr));
         check($sformatf("vec%0d_out_valid", i),  32'(out_valid),  32'(tbl[i].e_ov));
         check($sformatf("vec%0d_busy", i),       32'(busy),       32'(tbl[i].e_busy));
         check($sformatf("vec%0d_out_last", i),   32'(out_last),   32'(tbl[i].e_last));
         check($sformatf("vec%0d_out_data", i),   32'(out_data),   32'(tbl[i].e_od));
         check($sformatf("vec%0d_out_row", i),    32'(out_row),    32'(tbl[i].e_row));
         check($sformatf("vec%0d_out_col", i),    32'(out_col),    32'(tbl[i].e_col));
         @(negedge clock);
      end
      load_valid = 1'b0;
      load_data  = '0;
      out_ready  = 1'b0;
      abort      = 1'b0;

      // Full stream with continuous ready.
      do_load(pat);
      run_beats(NE, -1, 0, -1);
      idle_after("basic_end");

      // Three stall cycles while beat 5 is presented.
      do_load(pat);
      run_beats(NE, 4, 3, -1);
      idle_after("stall_end");

      // All-0xFF load offered during beat 3 must not disturb the stream.
      do_load(pat);
      run_beats(NE, -1, 0, 2);
      idle_after("ffload_end");

      // Abort alongside the beat-8 handshake, then a fresh stream from (0,0).
      do_load(pat);
      run_beats(7, -1, 0, -1);
      out_ready = 1'b1;
      abort     = 1'b1;
      #1;
      check("abort_beat8_data", 32'(out_data), exp_data(7));
      @(negedge clock);
      abort     = 1'b0;
      out_ready = 1'b0;
      #1;
      check("abort_busy",      32'(busy),       32'd0);
      check("abort_out_valid", 32'(out_valid),  32'd0);
      check("abort_load_rdy",  32'(load_ready), 32'd1);
      @(negedge clock);
      do_load(pat);
      run_beats(NE, -1, 0, -1);
      idle_after("restart_end");

      // Asynchronous reset during beat 10; no beats may follow release.
      do_load(pat);
      run_beats(9, -1, 0, -1);
      out_ready = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clock);
      reset = 1'b1;
      repeat (20) begin
         #1;
         check("post_reset_out_valid", 32'(out_valid), 32'd0);
         @(negedge clock);
      end
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter M_SIZE, default 4, matrix dimension (rows = columns).
REQ-002 SHALL have parameter VAR_WIDTH, default 8, bits per matrix element.
REQ-003 SHALL derive the local parameters N_ELEM = M_SIZE*M_SIZE and DATA_WIDTH = N_ELEM*VAR_WIDTH; IDX_W = clog2(M_SIZE), minimum 1.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port load_valid, input, 1, a packed result matrix is offered.
REQ-007 SHALL have port load_ready, output, 1, the block can accept a packed matrix.
REQ-008 SHALL have port load_data, input, DATA_WIDTH, the packed accumulator output from the MAC unit.
REQ-009 SHALL have port abort, input, 1, synchronous stream cancel.
REQ-010 SHALL have port out_valid, output, 1, an element is presented.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the element.
REQ-012 SHALL have port out_data, output, VAR_WIDTH, the element value.
REQ-013 SHALL have ports out_row and out_col, output, IDX_W each, the element coordinates.
REQ-014 SHALL have port out_last, output, 1, marks the final element of the matrix.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL pack element (r,c) of load_data in row-major order, MSB first: element index e = r*M_SIZE+c occupies bits [DATA_WIDTH-1-e*VAR_WIDTH -: VAR_WIDTH].
REQ-017 SHALL implement an FSM with two states, IDLE and STREAM.
REQ-018 SHALL drive load_ready = 1 only in IDLE; out_valid = 1 only in STREAM.
REQ-019 SHALL, in IDLE on load_valid&&load_ready, capture load_data into an internal shadow register, clear the beat counter, and enter STREAM on the next edge; the first out_valid therefore appears exactly 1 cycle after the load handshake.
REQ-020 SHALL ignore load_valid and hold the shadow register unchanged while in STREAM.
REQ-021 SHALL drive out_data, out_row, out_col and out_last combinationally from the shadow register and the beat counter; these SHALL hold stable while out_valid&&!out_ready.
REQ-022 SHALL advance the beat counter by one on each out_valid&&out_ready; out_last = 1 iff the counter equals N_ELEM-1.
REQ-023 SHALL return to IDLE on the handshake of the last beat; load_ready SHALL be 1 in the following cycle, so a new matrix can be accepted at the earliest one cycle after the last beat.
REQ-024 SHALL, on abort=1 in any state, enter IDLE on the next edge and clear the beat counter; abort has priority over a simultaneous out or load handshake, and that load is not captured.
REQ-025 SHALL produce exactly N_ELEM output handshakes per loaded matrix when no abort occurs; the counter never wraps past N_ELEM-1.

Reset
REQ-026 SHALL, while reset=0, force the state to IDLE, the beat counter to 0 and the shadow register to 0, giving load_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0 and busy=0.
REQ-027 SHALL discard any in-progress stream when reset is asserted mid-stream; no beats resume after release.

Configuration
REQ-028 SHALL support macro MMAC_STREAM_TRANSPOSE_EN: when defined, the beat counter maps to column-major order (beat b gives row = b mod M_SIZE, col = b / M_SIZE), so the transpose is emitted; when undefined, the order is row-major (row = b / M_SIZE, col = b mod M_SIZE).
REQ-029 SHALL keep out_row and out_col reporting the true coordinates of out_data in both configurations.

Verification
REQ-030 SHALL verify a basic stream: with default parameters, load elements e = 0x00..0x0F and hold out_ready=1 -> 16 beats with out_data 0x00..0x0F, (row,col) (0,0)..(3,3), out_last only on beat 16, and load_ready=1 in the cycle after.
REQ-031 SHALL verify backpressure: drop out_ready for 3 cycles at beat 5 -> out_data=0x04 with (1,0) held stable for those cycles, and the total beat count stays 16.
REQ-032 SHALL verify abort priority: assert abort together with the handshake of beat 8 -> busy=0 and out_valid=0 next cycle; a new load then restarts at (0,0).
REQ-033 SHALL verify reset mid-stream: drive reset=0 asynchronously during beat 10 -> outputs go to reset values immediately, and no further beats occur after release.
REQ-034 SHALL verify that a load is ignored during STREAM: pulse load_valid with all-0xFF data at beat 3 -> the remaining beats still carry the original data.
REQ-035 SHALL verify transpose: with MMAC_STREAM_TRANSPOSE_EN defined and the same load as REQ-030 -> out_data sequence 0x00,0x04,0x08,0x0C,0x01,..., and beat 2 reports (1,0).
